// File: rtl/share_reporter_if.sv
// Byte-stream and miner-hit signal bundle for share_reporter.
// The slave side is the reporter; the master side is the miner plus the host link.
interface share_reporter_if;
    logic         hit_valid;
    logic [31:0]  hit_nonce;
    logic [255:0] hit_hash;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        output hit_valid, hit_nonce, hit_hash, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  hit_valid, hit_nonce, hit_hash, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/share_reporter.sv
// Buffers winning nonce/hash pairs and streams each one as a 38-byte frame:
// sync byte, 4 nonce bytes, 32 hash bytes, XOR checksum of the 36 payload bytes.
module share_reporter #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                     clock,
    input  logic                     reset,
    share_reporter_if.slave          bus,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    output logic [15:0]              dropped_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [2:0] {IDLE, SYNC, NONCE, HASH, CSUM} state_t;

    logic [287:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s, empty_s, pop_s, push_s, drop_s, accept_s;

    state_t        state_r, state_s;
    logic [287:0]  shreg_r, shreg_s;
    logic [7:0]    csum_r, csum_s;
    logic [4:0]    idx_r, idx_s;
    logic [7:0]    tx_data_r, tx_data_s;
    logic          tx_valid_r, tx_valid_s;
    logic          overflow_r;
    logic [15:0]   dropped_r;

    // FIFO control: a pop in the same cycle frees room for a write when full.
    always_comb begin
        full_s   = (count_r == FULL_LEVEL);
        empty_s  = (count_r == {(AW+1){1'b0}});
        pop_s    = (state_r == IDLE) && !empty_s;
        push_s   = bus.hit_valid && (!full_s || pop_s);
        drop_s   = bus.hit_valid && full_s && !pop_s;
        accept_s = tx_valid_r && bus.tx_ready;
    end

    // FIFO storage; payload needs no reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem[wr_ptr_r] <= {bus.hit_nonce, bus.hit_hash};
        end
    end

    // FIFO pointers, occupancy and drop accounting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            dropped_r  <= 16'h0000;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (dropped_r != 16'hFFFF) dropped_r <= dropped_r + 16'h0001;
            end
        end
    end

    // Frame sequencer: next state, shift register, checksum and next output byte.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        csum_s  = csum_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    shreg_s = mem[rd_ptr_r];
                    csum_s  = 8'h00;
                    idx_s   = 5'd0;
                    state_s = SYNC;
                end else begin
                    state_s = IDLE;
                end
            end
            SYNC: begin
                if (accept_s) state_s = NONCE;
                else          state_s = SYNC;
            end
            NONCE, HASH: begin
                if (accept_s) begin
                    shreg_s = {shreg_r[279:0], 8'h00};
                    csum_s  = csum_r ^ shreg_r[287:280];
                    if (state_r == NONCE && idx_r == 5'd3) begin
                        idx_s   = 5'd0;
                        state_s = HASH;
                    end else if (state_r == HASH && idx_r == 5'd31) begin
                        idx_s   = 5'd0;
                        state_s = CSUM;
                    end else begin
                        idx_s   = idx_r + 5'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            CSUM: begin
                if (accept_s) state_s = IDLE;
                else          state_s = CSUM;
            end
            default: state_s = IDLE;
        endcase

        // Output byte is chosen from the next state so tx_data/tx_valid are plain flops.
        case (state_s)
            SYNC:        tx_data_s = SYNC_BYTE;
            NONCE, HASH: tx_data_s = shreg_s[287:280];
            CSUM:        tx_data_s = csum_s;
            default:     tx_data_s = 8'h00;
        endcase
        tx_valid_s = (state_s != IDLE);
    end

    // Sequencer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shreg_r    <= 288'h0;
            csum_r     <= 8'h00;
            idx_r      <= 5'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            csum_r     <= csum_s;
            idx_r      <= idx_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
        end
    end

    assign bus.tx_data    = tx_data_r;
    assign bus.tx_valid   = tx_valid_r;
    assign pending        = count_r;
    assign overflow       = overflow_r;
    assign dropped_count  = dropped_r;
endmodule

// File: doc/share_reporter.md
# share_reporter

Downstream of the miner control stage: captures each winning nonce/hash pair flagged by the miner's single-cycle success pulse, buffers the pairs in a small FIFO, and serializes each one as a fixed 38-byte frame over a valid/ready byte stream toward the host link (UART TX or debug port). It decouples the miner, which never stalls, from a slow output link, and counts shares lost to overflow.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high
- hit_valid  in  1  single-cycle pulse from the miner's hashSuccess
- hit_nonce  in  32  the miner's current_nonce, sampled with hit_valid
- hit_hash  in  256  the miner's satisfactoryHash, sampled with hit_valid
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts tx_data this cycle
- pending  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the frame in flight
- overflow  out  1  sticky; set when a hit is dropped
- dropped_count  out  16  dropped hits, saturating at 16'hFFFF

## Operation
- FIFO entry is {nonce[31:0], hash[255:0]}, 288 bits. Write on hit_valid when not full.
- hit_valid while full and no pop in the same cycle:
  - drop the hit
  - set overflow
  - increment dropped_count, saturating
- A write and a pop in the same cycle while full: the write is accepted and occupancy is unchanged.
- FSM states: IDLE, SYNC, NONCE, HASH, CSUM.
  - IDLE with FIFO non-empty: load the head into a 288-bit shift register, pop, clear the checksum, go to SYNC.
  - SYNC: tx_data = SYNC_BYTE. On acceptance (tx_valid & tx_ready), go to NONCE.
  - NONCE: 4 bytes, nonce[31:24] first.
  - HASH: 32 bytes, hash[255:248] first.
  - CSUM: 1 byte, the XOR of all 36 nonce and hash bytes (SYNC_BYTE is excluded). On acceptance, go to IDLE.
- A byte index counter tracks position within NONCE and HASH. The state advances only on acceptance.
- tx_valid is 1 in every state except IDLE. tx_data and tx_valid hold stable while tx_ready=0. tx_valid never deasserts before acceptance.
- The checksum accumulates each nonce and hash byte as it is accepted.
- overflow and dropped_count clear only on reset.

## Timing
- Reset (asynchronous):
  - state IDLE, FIFO empty, pointers 0
  - tx_valid=0, tx_data=0, pending=0, overflow=0, dropped_count=0
- Reset mid-frame aborts the frame. No partial frame resumes and buffered hits are discarded.
- Latency with idle FSM, empty FIFO and tx_ready held 1:
  - hit_valid high in cycle N
  - pending=1 in N+1, and the FSM loads/pops at the end of N+1
  - tx_valid=1 with SYNC_BYTE in N+2
- A frame takes exactly 38 accepted bytes. With tx_ready held 1 this is 38 consecutive cycles.
- There is exactly one IDLE cycle (tx_valid=0) between back-to-back frames.
- pending updates the cycle after a write or pop. The in-flight frame does not count.
- Hits arriving every cycle are all captured until the FIFO is full.

## Test plan
- Single hit, nonce=32'h42A14695, hash=256'h5A (all other bytes 0), tx_ready=1 → bytes A5, 42, A1, 46, 95, thirty-one 00, 5A, checksum 6A. tx_valid first rises 2 cycles after hit_valid; frame occupies 38 cycles.
- Backpressure: same hit, tx_ready toggling 1,0,0,1 repeating → same 38-byte sequence; tx_data is stable and tx_valid stays high during every stall.
- Overflow, DEPTH=4, tx_ready=0: six hits on consecutive cycles → first hit goes in flight, then pending=4, overflow=1, dropped_count=1. Releasing tx_ready gives 5 frames in hit order.
- Full plus simultaneous pop: FIFO full, hit_valid asserted in the cycle the FSM pops → hit stored, pending stays DEPTH, dropped_count unchanged.
- Saturation: force 70000 drops → dropped_count = 16'hFFFF, overflow=1.
- Reset mid-frame: assert reset after the 10th accepted byte → tx_valid=0 and pending=0 at once. A new hit afterwards produces a complete frame starting with A5.
